// File: rtl/yasac_uart_tx_pkg.sv
// Shared definitions for the YASAC port-mapped UART transmitter:
// FSM state encodings and control/status bit positions.
package yasac_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int CTRL_SEND = 0;
    localparam int CTRL_CLR  = 1;
    localparam int ST_BUSY   = 0;
    localparam int ST_OVR    = 1;

endpackage

// File: rtl/yasac_uart_tx_baud_tick.sv
// Bit-period divider: counts 0..DIVISOR-1 and wraps, flagging the last
// cycle of each period; a restart pulls the count back to zero.
module yasac_baud_tick #(
    parameter int DIVISOR = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The tick marks the final cycle of a bit period, so transitions happen on the wrap edge.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/yasac_uart_tx.sv
// 8N1 UART transmitter driven from YASAC output ports, with a polled
// status word {overrun, busy} for a YASAC input port.
module yasac_uart_tx
    import yasac_uart_tx_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] ctrl,
    output logic [7:0] status,
    output logic       tx,
    output logic       tx_done
);

    tx_state_t  state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       busy;
    logic       overrun;
    logic       prev_send;
    logic       tick;
    logic       send_req;
    logic       accept;
    logic       unused_ctrl;

    assign unused_ctrl = ^ctrl[7:2];
    assign send_req    = ctrl[CTRL_SEND] & ~prev_send;
    assign accept      = send_req && (state == IDLE);

    yasac_baud_tick #(
        .DIVISOR(DIVISOR)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .tick   (tick)
    );

    // prev_send resets high so a send bit held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            tx_done   <= 1'b0;
            prev_send <= 1'b1;
        end else begin
            prev_send <= ctrl[CTRL_SEND];
            tx_done   <= 1'b0;

            if (send_req && state != IDLE) begin
                overrun <= 1'b1;
            end else if (ctrl[CTRL_CLR]) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (send_req) begin
                        shreg <= data_in;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status          = 8'h00;
        status[ST_BUSY] = busy;
        status[ST_OVR]  = overrun;
    end

endmodule

// File: tb/tb_yasac_uart_tx.sv
// Scoreboard bench for yasac_uart_tx: a timeline model predicts line level,
// status and frame bytes; a monitor deserializes tx and checks each frame on tx_done.
module tb_yasac_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] ctrl = 8'h00;
    logic [7:0] status;
    logic       tx;
    logic       tx_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a frame is just a countdown of remaining line cycles
    int         m_left;
    logic [7:0] m_byte;
    logic       m_ovr;
    logic       m_prev;
    logic       m_done;
    logic [7:0] exp_q[$];

    yasac_uart_tx #(
        .DIVISOR(DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .ctrl   (ctrl),
        .status (status),
        .tx     (tx),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] c, input int cycles);
        data_in = d;
        ctrl    = c;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_byte <= 8'h00;
            m_ovr  <= 1'b0;
            m_prev <= 1'b1;
            m_done <= 1'b0;
            exp_q.delete();
        end else begin
            m_prev <= ctrl[0];
            m_done <= (m_left == 1);
            if (ctrl[0] && !m_prev && m_left == 0) begin
                m_left <= FRAME;
                m_byte <= data_in;
                exp_q.push_back(data_in);
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end
            if (ctrl[0] && !m_prev && m_left != 0) begin
                m_ovr <= 1'b1;
            end else if (ctrl[1]) begin
                m_ovr <= 1'b0;
            end
        end
    end

    // Monitor: per-cycle line/status checks plus a deserializer popping the scoreboard on tx_done
    initial begin : monitor
        logic       rx_active;
        int         rx_cnt;
        logic [7:0] rx_byte;
        logic [9:0] frame;
        logic       exp_tx;
        logic [7:0] exp_byte;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_byte   = 8'h00;
        forever begin
            @(negedge clk);
            if (m_left == 0) begin
                exp_tx = 1'b1;
            end else begin
                frame  = {1'b1, m_byte, 1'b0};
                exp_tx = frame[(FRAME - m_left) / DIV];
            end
            checkOutput("tx", {7'd0, tx}, {7'd0, exp_tx});
            checkOutput("status", status, {6'd0, m_ovr, (m_left != 0)});
            checkOutput("tx_done", {7'd0, tx_done}, {7'd0, m_done});

            if (!reset) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 6) % DIV == 0)
                    rx_byte[(rx_cnt - 6) / DIV] = tx;
                if (rx_cnt == FRAME - 1)
                    rx_active = 1'b0;
            end

            if (tx_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("frame_unexpected", rx_byte, ~rx_byte);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("frame_byte", rx_byte, exp_byte);
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset
        applyStimulus(8'h00, 8'h00, 20);

        // Single A5 frame
        applyStimulus(8'hA5, 8'h01, 45);
        applyStimulus(8'hA5, 8'h00, 2);

        // Overrun: second send edge mid-frame with different data
        applyStimulus(8'hA5, 8'h01, 12);
        applyStimulus(8'h3C, 8'h00, 1);
        applyStimulus(8'h3C, 8'h01, 35);
        applyStimulus(8'h3C, 8'h00, 5);
        applyStimulus(8'h3C, 8'h02, 1);
        applyStimulus(8'h3C, 8'h00, 3);

        // Back-to-back: new send edge lands exactly in the tx_done cycle
        applyStimulus(8'h11, 8'h01, 1);
        applyStimulus(8'h11, 8'h00, 40);
        checkOutput("b2b_done", {7'd0, tx_done}, 8'h01);
        applyStimulus(8'hFF, 8'h01, 45);
        applyStimulus(8'hFF, 8'h00, 2);

        // Random traffic with occasional overrun clears
        for (int i = 0; i < 400; i++) begin
            applyStimulus(8'($urandom),
                          {6'd0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0)}, 1);
        end
        applyStimulus(8'h00, 8'h02, 50);

        // Asynchronous reset during data bit 3
        applyStimulus(8'hA5, 8'h01, 1);
        applyStimulus(8'hA5, 8'h01, 17);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_tx", {7'd0, tx}, 8'h01);
        checkOutput("async_status", status, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(8'hA5, 8'h01, 50);

        // Send bit held high across reset release
        reset = 1'b0;
        applyStimulus(8'h5A, 8'h01, 3);
        reset = 1'b1;
        applyStimulus(8'h5A, 8'h01, 30);
        applyStimulus(8'h5A, 8'h00, 2);
        applyStimulus(8'h5A, 8'h01, 45);
        applyStimulus(8'h5A, 8'h00, 5);

        checkOutput("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
